// File: rtl/board_mover_if.sv
// board_mover_if: request/result bundle between the swipe controller and its
// neighbours (direction decoder on the request side, tile spawner on the
// result side).
//
// Handshake: start is a level sampled only while the mover is idle. A request
// is accepted on the clock edge where start=1 and the mover is idle; there is
// no queuing. busy is high from the cycle after acceptance until the swipe
// completes. done pulses for one cycle, and board_out/moved_any/score_add are
// valid from that cycle until the next accepted start. busy and done are never
// high together.
//
// Signals:
//   start     request a swipe (requester -> mover)
//   dir       00 left, 01 right, 10 up, 11 down; captured with start
//   board_in  cell (r,c) at bits [4*(4r+c)+3 : 4*(4r+c)], log2 of tile, 0 = empty
//   busy      swipe in progress
//   done      one-cycle completion pulse
//   board_out resulting board, same packing as board_in
//   moved_any any tile moved or merged during the swipe
//   score_add sum of merged tile values produced by the swipe
interface board_mover_if #(
  parameter int SCORE_W = 20
);
  logic               start;
  logic [1:0]         dir;
  logic [63:0]        board_in;
  logic               busy;
  logic               done;
  logic [63:0]        board_out;
  logic               moved_any;
  logic [SCORE_W-1:0] score_add;

  modport master (
    output start, dir, board_in,
    input  busy, done, board_out, moved_any, score_add
  );

  modport slave (
    input  start, dir, board_in,
    output busy, done, board_out, moved_any, score_add
  );
endinterface

// File: rtl/board_mover.sv
// board_mover: applies one 2048 swipe to a 4x4 board, one cell pair per clock.
// Each line is scanned from its swipe edge; a tile at scan position f is
// compared with its neighbour at f-1 by a combinational move_cell step and
// keeps sliding toward the edge while the step says to continue.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   bus       board_mover_if slave modport (start/dir/board_in in;
//             busy/done/board_out/moved_any/score_add out)
//   dbg_state current FSM state (0 IDLE, 1 STEP, 2 DONE)

// move_cell: one slide/merge decision between a tile and its edge-side
// neighbour. A merged value of 15+15 wraps to 0 in 4 bits.
module move_cell (
  input  logic [3:0] from,
  input  logic [3:0] to,
  input  logic       to_is_marked,
  output logic [3:0] next_from,
  output logic [3:0] next_to,
  output logic       cont,
  output logic       moved
);
  always_comb begin
    next_from = from;
    next_to   = to;
    cont      = 1'b0;
    moved     = 1'b0;
    if (from != 4'd0) begin
      if (to == 4'd0) begin
        // Slide into the empty cell and keep going toward the edge.
        next_to   = from;
        next_from = 4'd0;
        cont      = 1'b1;
        moved     = 1'b1;
      end else if ((to == from) && !to_is_marked) begin
        next_to   = to + 4'd1;
        next_from = 4'd0;
        moved     = 1'b1;
      end
    end
  end
endmodule

module board_mover #(
  parameter int SCORE_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  board_mover_if.slave       bus,
  output logic [1:0]         dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [1:0]         dir_q;
  logic [63:0]        board_q;
  logic [15:0]        mark_q;
  logic               moved_q;
  logic [SCORE_W-1:0] score_q;
  logic [1:0]         l_q, p_q, f_q;

  // Cell index {r,c} for line l, position p counted from the swipe edge.
  // For 2-bit values 3-p equals ~p.
  function automatic logic [3:0] cell_idx(input logic [1:0] d,
                                          input logic [1:0] l,
                                          input logic [1:0] p);
    case (d)
      2'd0:    cell_idx = {l, p};
      2'd1:    cell_idx = {l, ~p};
      2'd2:    cell_idx = {p, l};
      default: cell_idx = {~p, l};
    endcase
  endfunction

  logic [3:0] from_idx, to_idx;
  logic [3:0] from_val, to_val;
  logic [3:0] nx_from, nx_to;
  logic       mc_cont, mc_moved;
  logic       slide, scan_last;
  logic [4:0] to_p1;

  assign from_idx = cell_idx(dir_q, l_q, f_q);
  assign to_idx   = cell_idx(dir_q, l_q, f_q - 2'd1);
  assign from_val = board_q[{from_idx, 2'b00} +: 4];
  assign to_val   = board_q[{to_idx, 2'b00} +: 4];
  // 5-bit exponent so a 15+15 merge scores 2^16 even though the cell wraps.
  assign to_p1    = {1'b0, to_val} + 5'd1;

  move_cell u_move_cell (
    .from         (from_val),
    .to           (to_val),
    .to_is_marked (mark_q[to_idx]),
    .next_from    (nx_from),
    .next_to      (nx_to),
    .cont         (mc_cont),
    .moved        (mc_moved)
  );

  // Keep sliding the same tile while it still has a cell in front of it.
  assign slide     = mc_cont && (f_q != 2'd1);
  assign scan_last = (p_q == 2'd3) && (l_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = STEP;
      STEP:    if (!slide && scan_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= 2'd0;
      board_q <= 64'd0;
      mark_q  <= 16'd0;
      moved_q <= 1'b0;
      score_q <= '0;
      l_q     <= 2'd0;
      p_q     <= 2'd0;
      f_q     <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dir_q   <= bus.dir;
            board_q <= bus.board_in;
            mark_q  <= 16'd0;
            moved_q <= 1'b0;
            score_q <= '0;
            l_q     <= 2'd0;
            p_q     <= 2'd1;
            f_q     <= 2'd1;
          end
        end
        STEP: begin
          board_q[{from_idx, 2'b00} +: 4] <= nx_from;
          board_q[{to_idx, 2'b00} +: 4]   <= nx_to;
          if (mc_moved) moved_q <= 1'b1;
          if (mc_moved && !mc_cont) begin
            mark_q[to_idx] <= 1'b1;
            score_q        <= score_q + (SCORE_W'(1) << to_p1);
          end
          if (slide) begin
            f_q <= f_q - 2'd1;
          end else if (p_q != 2'd3) begin
            p_q <= p_q + 2'd1;
            f_q <= p_q + 2'd1;
          end else if (l_q != 2'd3) begin
            l_q <= l_q + 2'd1;
            p_q <= 2'd1;
            f_q <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q == STEP);
  assign bus.done      = (state_q == DONE);
  assign bus.board_out = board_q;
  assign bus.moved_any = moved_q;
  assign bus.score_add = score_q;
  assign dbg_state     = state_q;
endmodule
